// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants and the fetch FIFO entry layout.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_4;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Drop the byte-offset bits of an address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant + in-order rvalid bus.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with a clear that wins over push; head is read combinationally.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: the consumer qualifies the head with o_count.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_clear && !w_pop && (r_count == CNT_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(i_pop && !i_clear && (r_count == '0)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers returns for IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  PC_plus_4,
  output logic               fetch_bubble
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 2;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  w_outstanding_next;
  logic [CNT_W-1:0]  r_discard;
  logic [CNT_W-1:0]  w_discard_next;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_aq_count;
  logic [ADDR_W-1:0] w_aq_head;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;

  logic              w_pop;
  logic              w_req;
  logic              w_grant;
  logic              w_drop;
  logic              w_accept;
  logic [OCC_W-1:0]  w_occupancy;

  // Capacity counts buffered words, live requests and stale returns still owed.
  assign w_pop       = !stall && !flush && (w_count != '0);
  assign w_occupancy = OCC_W'(w_count) - OCC_W'(w_pop) + OCC_W'(r_outstanding) + OCC_W'(r_discard);
  assign w_req       = !reset && !flush && (w_occupancy < OCC_W'(DEPTH));
  assign w_grant     = w_req && imem.gnt;
  assign w_drop      = imem.rvalid && (flush || (r_discard != '0));
  assign w_accept    = imem.rvalid && !w_drop;

  always_comb begin
    w_pc_next          = r_pc;
    w_outstanding_next = r_outstanding;
    w_discard_next     = r_discard;
    if (flush) begin
      w_pc_next          = word_align(redirect_pc);
      w_outstanding_next = '0;
      w_discard_next     = r_discard + r_outstanding - CNT_W'(imem.rvalid);
    end else begin
      if (w_grant) w_pc_next = r_pc + ADDR_W'(4);
      if (imem.rvalid && (r_discard != '0)) w_discard_next = r_discard - CNT_W'(1);
      w_outstanding_next = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_accept);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
    end
  end

  // Per-request return address (addr+4), in grant order.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_addr_q (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_grant),
    .i_pop   (w_accept),
    .i_clear (flush),
    .i_data  (r_pc + ADDR_W'(4)),
    .o_count (w_aq_count),
    .o_head  (w_aq_head)
  );

  assign w_push_entry = '{instr: imem.rdata, pc_plus_4: w_aq_head};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_data_q (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign imem.req     = w_req;
  assign imem.addr    = r_pc;
  assign fetch_bubble = (w_count == '0);
  assign Instruction  = fetch_bubble ? NOP_INSTR : w_head.instr;
  assign PC_plus_4    = fetch_bubble ? '0 : w_head.pc_plus_4;

  a_addr_q_tracks: assert property (@(posedge clk) disable iff (reset)
    w_aq_count == r_outstanding);

  a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
    imem.rvalid |-> ((r_outstanding != '0) || (r_discard != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised fetch_unit bench: memory model with random grant/latency, program-order scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] redirect_pc;
  logic [31:0] Instruction, PC_plus_4;
  logic        fetch_bubble;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .imem         (imem),
    .Instruction  (Instruction),
    .PC_plus_4    (PC_plus_4),
    .fetch_bubble (fetch_bubble)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within bound (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 ^ (a * 32'h9E37_79B9);
  endfunction

  // ---------------- scoreboard: program-order stream since last redirect ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_next;
  exp_t        mon_e;

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 32) begin
      e.instr = mem_word(exp_next);
      e.pc4   = exp_next + 32'd4;
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc & 32'hFFFF_FFFC;
    refill();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (flush) check("req_during_flush", {31'b0, imem.req}, 32'd0);
      if (fetch_bubble) begin
        check("bubble_instr", Instruction, NOP_INSTR);
        check("bubble_pc4", PC_plus_4, 32'd0);
      end else if (!stall && !flush) begin
        if (exp_q.size() == 0) begin
          fail_now("capture_expected_entry");
        end else begin
          mon_e = exp_q.pop_front();
          check("capture_instr", Instruction, mon_e.instr);
          check("capture_pc4", PC_plus_4, mon_e.pc4);
          refill();
        end
      end
    end
  end

  // ---------------- instruction memory model ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    cyc     = 0;
  int    gnt_pct = 100;
  int    lat_lo  = 1;
  int    lat_hi  = 1;
  int    mem_due;

  initial begin
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
      end else begin
        if (imem.rvalid) void'(pend.pop_front());
        if (imem.req && imem.gnt) begin
          mem_due = cyc + int'($urandom_range(lat_hi, lat_lo));
          if (pend.size() > 0 && mem_due <= pend[pend.size()-1].due)
            mem_due = pend[pend.size()-1].due + 1;
          pend.push_back('{imem.addr, mem_due});
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem.gnt = (int'($urandom_range(99, 0)) < gnt_pct);
      if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(pend[0].addr);
      end else begin
        imem.rvalid = 1'b0;
        imem.rdata  = $urandom;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] hold_i, hold_p;
  bit          found;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_head(input string name, input logic [31:0] exp_pc4);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!fetch_bubble) seen = 1'b1;
      else tick();
    end
    if (seen) check(name, PC_plus_4, exp_pc4);
    else fail_now(name);
  endtask

  task automatic wait_pending(input string name, input int n, input bit rv);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pend.size() == n && imem.rvalid == rv) found = 1'b1;
    end
    if (!found) fail_now(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    restart(RESET_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pc4", PC_plus_4, 32'h0);
    check("rst_bubble", {31'b0, fetch_bubble}, 32'd1);
    check("rst_req", {31'b0, imem.req}, 32'd0);
    check("rst_addr", imem.addr, RESET_PC);

    // Reset release, L=1, grant always: first head in cycle 2.
    tick(); reset = 1'b0; restart(RESET_PC);
    @(negedge clk);
    check("c0_addr", imem.addr, RESET_PC);
    check("c0_req", {31'b0, imem.req}, 32'd1);
    tick(); @(negedge clk);
    check("c1_bubble", {31'b0, fetch_bubble}, 32'd1);
    tick(); @(negedge clk);
    check("c2_instr", Instruction, 32'h2008_0005);

    // Streaming: one instruction per cycle.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick(); @(negedge clk); end
      check("stream_pc4", PC_plus_4, 32'(4 * (i + 1)));
      check("stream_bubble", {31'b0, fetch_bubble}, 32'd0);
    end

    // Stall: head held, requests stop once the FIFO is full.
    tick(); stall = 1'b1;
    @(negedge clk);
    hold_i = Instruction; hold_p = PC_plus_4;
    repeat (2) begin tick(); @(negedge clk); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick(); @(negedge clk); end
      check("stall_instr", Instruction, hold_i);
      check("stall_pc4", PC_plus_4, hold_p);
      check("stall_req", {31'b0, imem.req}, 32'd0);
      check("stall_bubble", {31'b0, fetch_bubble}, 32'd0);
    end
    tick(); stall = 1'b0;
    repeat (4) tick();

    // Redirect with two requests in flight at L=3.
    lat_lo = 3; lat_hi = 3;
    wait_pending("redirect_setup", 2, 1'b0);
    flush = 1'b1; redirect_pc = 32'h0000_0100; restart(32'h0000_0100);
    tick(); flush = 1'b0;
    wait_head("redirect_pc4", 32'h0000_0104);

    // Same redirect with stall raised in the flush cycle.
    wait_pending("redirect_stall_setup", 2, 1'b0);
    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0300; restart(32'h0000_0300);
    tick(); flush = 1'b0; stall = 1'b0;
    wait_head("redirect_stall_pc4", 32'h0000_0304);

    // Wrap and alignment at L=1 from a steady stream.
    lat_lo = 1; lat_hi = 1;
    repeat (6) tick();
    wait_pending("wrap_setup", 1, 1'b1);
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFE; restart(32'hFFFF_FFFE);
    tick(); flush = 1'b0;
    @(negedge clk);
    check("wrap_addr0", imem.addr, 32'hFFFF_FFFC);
    check("wrap_req0", {31'b0, imem.req}, 32'd1);
    tick(); @(negedge clk);
    check("wrap_addr1", imem.addr, 32'h0000_0000);
    tick(); @(negedge clk);
    check("wrap_instr", Instruction, mem_word(32'hFFFF_FFFC));
    check("wrap_pc4_0", PC_plus_4, 32'h0000_0000);
    tick(); @(negedge clk);
    check("wrap_pc4_1", PC_plus_4, 32'h0000_0004);

    // Random traffic: grant gaps, variable latency, stalls, redirects.
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      tick();
      stall = (int'($urandom_range(99, 0)) < 25);
      if (int'($urandom_range(99, 0)) < 4) begin
        redirect_pc = $urandom;
        if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        flush = 1'b1;
        restart(redirect_pc);
      end else begin
        flush = 1'b0;
      end
    end
    tick(); flush = 1'b0; stall = 1'b0;

    // Asynchronous reset mid-stream with the FIFO full.
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (4) tick();
    stall = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("prerst_bubble", {31'b0, fetch_bubble}, 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_instr", Instruction, 32'h0);
    check("arst_pc4", PC_plus_4, 32'h0);
    check("arst_bubble", {31'b0, fetch_bubble}, 32'd1);
    check("arst_req", {31'b0, imem.req}, 32'd0);
    restart(RESET_PC);
    tick(); reset = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("postrst_addr", imem.addr, RESET_PC);
    check("postrst_req", {31'b0, imem.req}, 32'd1);
    tick();
    wait_head("postrst_pc4", RESET_PC + 32'd4);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
